// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// FSM state encoding, error-flag bit positions and the debug view.
package uart_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit positions of the per-word error flags, above the data bits
  localparam int FERR = 0;
  localparam int PERR = 1;
  localparam int BRK  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_PUSH  = 3'd5
  } uart_state_e;

  // Internal state made visible for checkers
  typedef struct packed {
    uart_state_e state;
    logic        armed;
    logic        fifo_full;
  } uart_dbg_t;

endpackage

// File: rtl/uart_rec_param_if.sv
// Host-side receive port of the UART receiver.
//
// Handshake: rec_validH high means rec_dataH/rec_errH hold the FIFO head.
// The consumer pops by holding rec_ackH high for one rising edge while
// rec_validH is high; the next entry (or zero) appears after that edge.
// rec_ackH while rec_validH is low has no effect. overrunH is a one-cycle
// pulse and needs no acknowledge.
interface uart_rec_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]      rec_dataH;
  logic [2:0]             rec_errH;
  logic                   rec_validH;
  logic                   rec_ackH;
  logic                   overrunH;
  logic [$clog2(DEPTH):0] fifo_cntH;

  modport master (
    output rec_dataH, rec_errH, rec_validH, overrunH, fifo_cntH,
    input  rec_ackH
  );

  modport slave (
    input  rec_dataH, rec_errH, rec_validH, overrunH, fifo_cntH,
    output rec_ackH
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO with a registered head output.
// A write when full is dropped and flagged on overrun_o in the same cycle,
// unless a read in that cycle frees a slot.
module uart_rx_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   overrun_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_rd, do_wr;

  // Next-state: accepted read/write, pointers, count and the new head word
  always_comb begin
    do_rd    = rd_en_i && (cnt_q != '0);
    do_wr    = wr_en_i && ((cnt_q != CW'(DEPTH)) || do_rd);
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (do_wr && (cnt_q == CW'(do_rd))) begin
      // FIFO is (or becomes) empty this cycle: the new word is the head
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Pointer, count and head registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents need no reset since the count guards reads
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = head_q;
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign overrun_o = wr_en_i && !do_wr;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/uart_rec_param.sv
// Parametrised oversampling UART receiver: input synchroniser, bit-cell
// counter and frame FSM feeding a FWFT receive FIFO with per-word flags.
module uart_rec_param
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ovs_tickH,
  input  logic              uart_dataH,
  uart_rec_param_if.master  rec_if,
  output uart_dbg_t         dbg_o
);
  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int FW    = DATA_W + 3;

  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C    = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  logic              meta_q, sync_q;
  logic [1:0]        fill_q;
  logic              armed_q;
  uart_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bit_q;
  logic              frame_q;

  logic              rx;
  logic              sample;
  logic              perr_w, brk_w;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     fifo_head;
  logic              fifo_empty, fifo_full;

  assign rx = sync_q;

  // The start bit is sampled half a cell in, every later bit a full cell on
  assign sample = ovs_tickH &&
                  (cnt_q == ((state_q == ST_START) ? HALF_C : FULL_C));

  // Flags for the word being pushed
  assign perr_w = (PARITY == PAR_NONE) ? 1'b0 :
                  ((^shift_q ^ par_bit_q) != (PARITY == PAR_ODD));
  assign brk_w  = frame_q && (shift_q == '0) &&
                  ((PARITY == PAR_NONE) || !par_bit_q);

  // Assemble {break, parity, frame, data} for the FIFO
  always_comb begin
    push_word                = '0;
    push_word[DATA_W-1:0]    = shift_q;
    push_word[DATA_W + FERR] = frame_q;
    push_word[DATA_W + PERR] = perr_w;
    push_word[DATA_W + BRK]  = brk_w;
  end

  // Synchroniser, bit-cell counter and frame FSM
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      meta_q <= uart_dataH;
      sync_q <= meta_q;
      // fill_q[1] marks sync_q as holding a real pin sample, not reset value
      fill_q <= {fill_q[0], 1'b1};
      if (ovs_tickH) cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rx && fill_q[1]) begin
            armed_q <= 1'b1;
          end else if (armed_q && !rx) begin
            state_q <= ST_START;
            armed_q <= 1'b0;
            bit_q   <= '0;
            frame_q <= 1'b0;
          end
        end
        ST_START: begin
          if (sample) begin
            cnt_q   <= '0;
            state_q <= rx ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            cnt_q   <= '0;
            shift_q <= {rx, shift_q[DATA_W-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        ST_PAR: begin
          if (sample) begin
            cnt_q     <= '0;
            par_bit_q <= rx;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            cnt_q <= '0;
            // A low stop sample leaves the receiver waiting for a real edge
            armed_q <= rx;
            if (!rx) frame_q <= 1'b1;
            if (bit_q == LAST_STOP) begin
              state_q <= ST_PUSH;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        ST_PUSH: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (state_q == ST_PUSH),
    .wr_data_i (push_word),
    .rd_en_i   (rec_if.rec_ackH),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .overrun_o (rec_if.overrunH),
    .cnt_o     (rec_if.fifo_cntH)
  );

  assign rec_if.rec_dataH  = fifo_head[DATA_W-1:0];
  assign rec_if.rec_errH   = fifo_head[DATA_W +: 3];
  assign rec_if.rec_validH = !fifo_empty;

  assign dbg_o = '{state: state_q, armed: armed_q, fifo_full: fifo_full};

endmodule

// File: doc/uart_rec_param.md
# uart_rec_param

Parametrised next-generation UART receiver: oversampled serial-to-parallel conversion with configurable data width, parity mode and stop-bit count. Adds per-word error flagging (framing, parity, break) and a first-word-fall-through receive FIFO with overrun reporting. Sits between the external serial line and the host-side consumer, alongside the existing transmitter.

## Interface
- DATA_W, 8: data bits per frame, legal 5..9
- OVS, 16: oversample ticks per bit, legal 8..32, even
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- DEPTH, 4: FIFO entries, power of 2, >= 2

- sys_clk  in  1  single clock, all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- ovs_tickH  in  1  oversample enable; tie high for OVS clocks per bit
- uart_dataH  in  1  asynchronous serial line, idle high
- rec_dataH  out  DATA_W  FIFO head data, LSB = first received bit
- rec_errH  out  3  FIFO head flags {break, parity, frame}
- rec_validH  out  1  FIFO non-empty
- rec_ackH  in  1  pops head when rec_validH high; ignored when empty
- overrunH  out  1  one-cycle pulse: completed word dropped, FIFO full
- fifo_cntH  out  $clog2(DEPTH)+1  current occupancy

## Operation
- uart_dataH passes a 2-flop synchroniser (both reset to 1); the FSM sees only the synchronised bit.
- Bit-cell counter: $clog2(OVS) bits, advances only on ovs_tickH, cleared on every state change.
- States: IDLE, START, DATA, PAR, STOP, PUSH.
- IDLE: arm only after a synchronised high has been seen since reset. A high-to-low transition goes to START.
- START: at count OVS/2-1, sample the line. Low goes to DATA. High is a false start: return to IDLE, no push.
- DATA: sample at each bit centre, i.e. every OVS ticks after the start sample. Shift in LSB first. After DATA_W samples, go to PAR if PARITY != 0, else STOP.
- PAR: sample one bit. parity error = (XOR of data ^ sampled bit) != (PARITY==1 ? 1 : 0).
- STOP: sample STOP_BITS bits. Any low sample sets frame error.
- Break = frame error AND all data bits 0 AND (no parity or parity bit 0).
- PUSH: one cycle. Write {break, parity, frame, data} into the FIFO, then go to IDLE. The next start edge can be detected in the cycle after PUSH.
- Erroneous words are still pushed, with their flags.
- FIFO full at PUSH: the word is discarded, FIFO contents are unchanged, and overrunH pulses in the same cycle as the attempted write.
- Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted. The count stays at DEPTH and overrunH stays low.
- Push and pop in the same cycle when empty: the push lands and the count becomes 1. The ack is ignored.
- Pointers wrap modulo DEPTH. The count distinguishes full from empty.

## Timing
- Reset values: rec_dataH=0, rec_errH=0, rec_validH=0, overrunH=0, fifo_cntH=0, FSM=IDLE, IDLE not yet armed.
- Reset mid-frame discards the partial word and empties the FIFO. A line held low through reset release is not a start; a rising then falling edge is required.
- Latency with ovs_tickH=1: the centre of the last stop bit is sampled, PUSH follows next cycle, and rec_validH and rec_dataH are valid the cycle after PUSH.
- Synchroniser adds 2 cycles from pin to FSM.
- rec_dataH/rec_errH are registered FIFO head outputs. After an ack, the next entry (or 0 when empty) appears on the following cycle.
- ovs_tickH low freezes the bit-cell counter and sampling. FSM state is held.

## Structure
- Package uart_pkg holds:
  - parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2)
  - FSM state encoding, 3 bits
  - error-flag bit positions (FERR=0, PERR=1, BRK=2)
- Sub-module uart_rx_fifo: generic FWFT FIFO parametrised by width (DATA_W+3) and DEPTH. It provides full, empty, count and overrun-on-write-when-full.
- The top level holds the synchroniser, bit-cell counter and FSM.

## Test plan
- Defaults, ovs_tickH=1, send 0xA5 with 16 clocks/bit: rec_dataH=0xA5, rec_errH=0, rec_validH high 2 cycles after the stop-bit centre. Ack, then rec_validH=0.
- PARITY=2, send 0x07 with parity bit 0 (wrong): word pushed with rec_errH=3'b010. With parity 1: rec_errH=0.
- STOP_BITS=2, second stop bit driven low on 0x3C: rec_errH=3'b001. Line held low 12 bit-times: data 0x00, rec_errH=3'b101.
- Start pulse low for 5 clocks only: no push, FSM back in IDLE, fifo_cntH=0.
- DEPTH=4, five back-to-back frames 0x01..0x05, no ack: fifo_cntH=4 and overrunH pulses once on the fifth. Drain order is 0x01..0x04. With ack asserted during the fifth PUSH: no overrun, 0x05 retained.
- Assert sys_rst for 1 cycle during bit 3 of a frame while the line is low: all outputs 0. Next valid frame 0x5A received correctly only after the line returns high.
